// File: rtl/alu_arbiter.sv
// Purpose : round-robin arbiter sharing one ALU between two requesters, one op in flight at a time.
// Latency : accept edge -> rsp_valid high ALU_LAT edges later; one op per ALU_LAT+2 cycles at best.
// Backpr. : readies are low outside IDLE; the response holds stable until rsp_ready, then returns to IDLE.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   req{0,1}_valid/ready       request handshake (ready is combinational in IDLE)
//   req{0,1}_A/B/opcode        request operands and opcode
//   rsp_valid/ready            response handshake
//   rsp_id/result/flags        requester id, captured result, {carryout,overflow,zero}
//   alu_A/B/opcode             registered operands/opcode driven to the ALU
//   alu_result/carryout/overflow/zero  ALU outputs, sampled ALU_LAT edges after issue
module alu_arbiter #(
  parameter int NUMBITS = 8,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [NUMBITS-1:0] req0_A,
  input  logic [NUMBITS-1:0] req0_B,
  input  logic [2:0]         req0_opcode,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [NUMBITS-1:0] req1_A,
  input  logic [NUMBITS-1:0] req1_B,
  input  logic [2:0]         req1_opcode,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [NUMBITS-1:0] rsp_result,
  output logic [2:0]         rsp_flags,
  output logic [NUMBITS-1:0] alu_A,
  output logic [NUMBITS-1:0] alu_B,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ptr;       // 0: req0 has priority on a tie, 1: req1
  logic               r_id;
  logic [NUMBITS-1:0] r_alu_a;
  logic [NUMBITS-1:0] r_alu_b;
  logic [2:0]         r_alu_op;
  logic               r_rsp_vld;
  logic [NUMBITS-1:0] r_rsp_res;
  logic [2:0]         r_rsp_flg;

  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_accept;
  logic               w_capture;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, grant and strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A lone requester always wins; the pointer only breaks ties.
        if (req0_valid && (!req1_valid || !r_ptr)) begin
          w_gnt0 = 1'b1;
        end else if (req1_valid) begin
          w_gnt1 = 1'b1;
        end
        if (w_gnt0 || w_gnt1) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: issue registers, latency counter, pointer and response capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_ptr     <= 1'b0;
      r_id      <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_res <= '0;
      r_rsp_flg <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= w_gnt1 ? req1_A      : req0_A;
        r_alu_b  <= w_gnt1 ? req1_B      : req0_B;
        r_alu_op <= w_gnt1 ? req1_opcode : req0_opcode;
        r_id     <= w_gnt1;
        r_ptr    <= w_gnt0;   // hand priority to the requester that just lost
        r_cnt    <= CNT_W'(ALU_LAT - 1);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_capture) begin
        r_rsp_vld <= 1'b1;
        r_rsp_res <= alu_result;
        r_rsp_flg <= {alu_carryout, alu_overflow, alu_zero};
      end else if (r_state == S_RESP && rsp_ready) begin
        r_rsp_vld <= 1'b0;
      end
    end
  end

  // Readies are forced low while reset is held so every output reads 0 in reset.
  assign req0_ready = w_gnt0 & reset;
  assign req1_ready = w_gnt1 & reset;

  assign rsp_valid  = r_rsp_vld;
  assign rsp_id     = r_id;
  assign rsp_result = r_rsp_res;
  assign rsp_flags  = r_rsp_flg;
  assign alu_A      = r_alu_a;
  assign alu_B      = r_alu_b;
  assign alu_opcode = r_alu_op;

endmodule
